// File: rtl/floating_to_fixed_conversion_if.sv
// Handshake and data bundle between a caller and the float-to-Q10.22 converter.
interface floating_to_fixed_conversion_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start_floating_to_fixed_conversion;
   logic [DATA_WIDTH-1:0] floating_point_input;
   logic [DATA_WIDTH-1:0] fixed_point_output_reg;
   logic                  fixed_point_number_ready;
   logic                  busy;
   logic                  range_error;

   modport master (
      output start_floating_to_fixed_conversion,
      output floating_point_input,
      input  fixed_point_output_reg,
      input  fixed_point_number_ready,
      input  busy,
      input  range_error
   );

   modport slave (
      input  start_floating_to_fixed_conversion,
      input  floating_point_input,
      output fixed_point_output_reg,
      output fixed_point_number_ready,
      output busy,
      output range_error
   );
endinterface

// File: rtl/floating_to_fixed_conversion.sv
// Multi-cycle IEEE-754 single to unsigned Q10.22 converter (start/ready handshake).
// Define FLOAT_TO_FIXED_SATURATE_EN to saturate overflow/Inf/NaN to all-ones.
module floating_to_fixed_conversion #(
   parameter int DATA_WIDTH = 32,
   parameter int M          = 23,
   parameter int E          = 8,
   parameter int bias       = 127,
   parameter int INTEGER    = 10,
   parameter int FRACTION   = 22
) (
   input logic                           clk,
   input logic                           reset,
   floating_to_fixed_conversion_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      DECODE       = 2'b01,
      SHIFT        = 2'b11,
      OUTPUT_READY = 2'b10
   } state_t;

   // 1.m x 2^(e-bias) as Q10.22 equals m24 x 2^(e - (bias + M - FRACTION)).
   localparam logic signed [E:0]   K_OFS     = (E+1)'(bias + M - FRACTION);
   localparam logic [E-1:0]        OVF_EXP   = E'(bias + INTEGER);
   localparam logic [E:0]          SHL_LIM   = (E+1)'(DATA_WIDTH);
   localparam logic [E:0]          SHR_LIM   = (E+1)'(M + 1);
   localparam logic [DATA_WIDTH-1:0] FIXED_MAX = '1;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   in_q, in_d;
   logic [M:0]              m24_q, m24_d;
   logic signed [E:0]       k_q, k_d;
   logic                    zero_q, zero_d;
   logic                    neg_q, neg_d;
   logic                    inf_nan_q, inf_nan_d;
   logic                    ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0]   out_q, out_d;
   logic                    range_error_q, range_error_d;

   logic [E-1:0]            exp_field;
   logic [M-1:0]            man_field;
   logic [DATA_WIDTH-1:0]   scaled;

   function automatic logic [DATA_WIDTH-1:0] scale_mantissa(input logic [M:0] m24,
                                                            input logic signed [E:0] k);
      logic [2*DATA_WIDTH-1:0] wide;
      logic [E:0]              amt;
      logic [M:0]              narrow;
      scale_mantissa = '0;
      wide   = {{(2*DATA_WIDTH-M-1){1'b0}}, m24};
      narrow = '0;
      if (!k[E]) begin
         amt = $unsigned(k);
         if (amt < SHL_LIM) begin
            wide = wide << amt;
            scale_mantissa = wide[DATA_WIDTH-1:0];
         end
      end else begin
         amt = $unsigned(-k);
         if (amt < SHR_LIM) begin
            narrow = m24 >> amt;
            scale_mantissa = {{(DATA_WIDTH-M-1){1'b0}}, narrow};
         end
      end
   endfunction

   assign exp_field = in_q[DATA_WIDTH-2 -: E];
   assign man_field = in_q[M-1:0];
   assign scaled    = scale_mantissa(m24_q, k_q);

   always_comb begin
      state_d       = state_q;
      in_d          = in_q;
      m24_d         = m24_q;
      k_d           = k_q;
      zero_d        = zero_q;
      neg_d         = neg_q;
      inf_nan_d     = inf_nan_q;
      ovf_d         = ovf_q;
      out_d         = out_q;
      range_error_d = range_error_q;
      case (state_q)
         IDLE: begin
            if (bus.start_floating_to_fixed_conversion) begin
               in_d    = bus.floating_point_input;
               state_d = DECODE;
            end
         end
         DECODE: begin
            m24_d     = {1'b1, man_field};
            k_d       = $signed({1'b0, exp_field}) - K_OFS;
            zero_d    = (exp_field == '0);
            neg_d     = in_q[DATA_WIDTH-1];
            inf_nan_d = (exp_field == '1);
            ovf_d     = (exp_field >= OVF_EXP);
            state_d   = SHIFT;
         end
         SHIFT: begin
            // Zero/denormal beats sign so that -0.0 is not flagged.
            if (zero_q) begin
               out_d         = '0;
               range_error_d = 1'b0;
            end else if (neg_q) begin
               out_d         = '0;
               range_error_d = 1'b1;
            end else if (inf_nan_q || ovf_q) begin
               range_error_d = 1'b1;
`ifdef FLOAT_TO_FIXED_SATURATE_EN
               out_d         = FIXED_MAX;
`else
               out_d         = inf_nan_q ? '0 : scaled;
`endif
            end else begin
               out_d         = scaled;
               range_error_d = 1'b0;
            end
            state_d = OUTPUT_READY;
         end
         OUTPUT_READY: state_d = IDLE;
         default:      state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         in_q          <= '0;
         m24_q         <= '0;
         k_q           <= '0;
         zero_q        <= 1'b0;
         neg_q         <= 1'b0;
         inf_nan_q     <= 1'b0;
         ovf_q         <= 1'b0;
         out_q         <= '0;
         range_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         in_q          <= in_d;
         m24_q         <= m24_d;
         k_q           <= k_d;
         zero_q        <= zero_d;
         neg_q         <= neg_d;
         inf_nan_q     <= inf_nan_d;
         ovf_q         <= ovf_d;
         out_q         <= out_d;
         range_error_q <= range_error_d;
      end
   end

   assign bus.fixed_point_output_reg   = out_q;
   assign bus.fixed_point_number_ready = (state_q == OUTPUT_READY);
   assign bus.busy                     = (state_q != IDLE);
   assign bus.range_error              = range_error_q;
endmodule

// File: tb/tb_floating_to_fixed_conversion.sv
// Randomized bench for floating_to_fixed_conversion with a real-arithmetic reference model.
module tb_floating_to_fixed_conversion;
`ifdef FLOAT_TO_FIXED_SATURATE_EN
   localparam bit          SAT     = 1'b1;
   localparam logic [31:0] OOR_VAL = 32'hFFFF_FFFF;
`else
   localparam bit          SAT     = 1'b0;
   localparam logic [31:0] OOR_VAL = 32'h0000_0000;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;

   floating_to_fixed_conversion_if #(.DATA_WIDTH(32)) bus ();

   floating_to_fixed_conversion dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference: value x 2^22, truncated, evaluated in real arithmetic.
   function automatic logic [32:0] model_conv(input logic [31:0] x);
      int     e;
      int     k;
      longint m24;
      longint f;
      real    v;
      e   = int'(x[30:23]);
      m24 = longint'({1'b1, x[22:0]});
      k   = e - 128;
      if (e == 0)   return {1'b0, 32'h0};
      if (x[31])    return {1'b1, 32'h0};
      if (e == 255) return {1'b1, (SAT ? 32'hFFFF_FFFF : 32'h0)};
      if (e >= 137) begin
         if (SAT)     return {1'b1, 32'hFFFF_FFFF};
         if (k >= 32) return {1'b1, 32'h0};
         f = m24 << k;
         return {1'b1, f[31:0]};
      end
      v = real'(m24);
      if (k >= 0) repeat (k) v = v * 2.0;
      else        repeat (-k) v = v / 2.0;
      f = longint'($floor(v));
      return {1'b0, f[31:0]};
   endfunction

   function automatic logic [31:0] rand_float();
      int         sel;
      logic       s;
      logic [7:0] e;
      logic [31:0] m;
      sel = $urandom_range(0, 9);
      s   = 1'b0;
      m   = $urandom;
      case (sel)
         0:       e = 8'h00;
         1:       begin e = 8'hFF; s = 1'($urandom_range(0, 1)); end
         2:       begin e = 8'($urandom_range(1, 254)); s = 1'b1; end
         default: e = 8'($urandom_range(95, 145));
      endcase
      return {s, e, m[22:0]};
   endfunction

   // Model: phase counts remaining busy cycles (3..1), 0 when idle.
   int          phase = 0;
   logic [32:0] pend;
   logic [31:0] e_out = '0;
   logic        e_re  = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         phase = 0;
         e_out = '0;
         e_re  = 1'b0;
      end else if (phase == 0) begin
         if (bus.start_floating_to_fixed_conversion) begin
            phase = 3;
            pend  = model_conv(bus.floating_point_input);
         end
      end else begin
         phase = phase - 1;
         if (phase == 1) begin
            e_out = pend[31:0];
            e_re  = pend[32];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",        64'(bus.busy),                     64'(phase != 0));
         chk("ready",       64'(bus.fixed_point_number_ready), 64'(phase == 1));
         chk("out",         64'(bus.fixed_point_output_reg),   64'(e_out));
         chk("range_error", 64'(bus.range_error),              64'(e_re));
      end
   end

   task automatic run_conv(input logic [31:0] x, input bit disturb,
                           output logic [31:0] v, output logic re, output int lat);
      @(negedge clk);
      bus.start_floating_to_fixed_conversion = 1'b1;
      bus.floating_point_input = x;
      @(negedge clk);
      lat = 1;
      if (disturb) begin
         bus.start_floating_to_fixed_conversion = 1'b1;
         bus.floating_point_input = ~x;
      end else begin
         bus.start_floating_to_fixed_conversion = 1'b0;
         bus.floating_point_input = $urandom;
      end
      while (!bus.fixed_point_number_ready && lat < 10) begin
         @(negedge clk);
         lat++;
         bus.start_floating_to_fixed_conversion = 1'b0;
      end
      v  = bus.fixed_point_output_reg;
      re = bus.range_error;
   endtask

   logic [31:0] vec_in  [9] = '{32'h3F80_0000, 32'h4060_0000, 32'h3F00_0000, 32'h447F_C000,
                                32'h4480_0000, 32'h7F80_0000, 32'hBF80_0000, 32'h0000_0001,
                                32'h3300_0000};
   logic [31:0] vec_out [9] = '{32'h0040_0000, 32'h00E0_0000, 32'h0020_0000, 32'hFFC0_0000,
                                OOR_VAL,       OOR_VAL,       32'h0,         32'h0,
                                32'h0};
   logic        vec_re  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      logic [31:0] v;
      logic        re;
      int          lat;
      int          pulses;
      string       nm;

      reset = 1'b1;
      bus.start_floating_to_fixed_conversion = 1'b0;
      bus.floating_point_input = '0;

      // Pin the model against hand-computed values.
      for (int i = 0; i < 9; i++) begin
         nm = $sformatf("model_%h", vec_in[i]);
         chk(nm, 64'(model_conv(vec_in[i])), 64'({vec_re[i], vec_out[i]}));
      end
      chk("model_neg_zero", 64'(model_conv(32'h8000_0000)), 64'(33'h0));

      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_out",   64'(bus.fixed_point_output_reg),   64'h0);
      chk("rst_ready", 64'(bus.fixed_point_number_ready), 64'h0);
      chk("rst_busy",  64'(bus.busy),                     64'h0);
      chk("rst_re",    64'(bus.range_error),              64'h0);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_conv(vec_in[i], 1'b0, v, re, lat);
         chk($sformatf("lat_%h", vec_in[i]), 64'(lat), 64'd3);
         chk($sformatf("val_%h", vec_in[i]), 64'(v),   64'(vec_out[i]));
         chk($sformatf("re_%h",  vec_in[i]), 64'(re),  64'(vec_re[i]));
      end

      run_conv(32'h8000_0000, 1'b0, v, re, lat);
      chk("neg_zero_val", 64'(v), 64'h0);
      chk("neg_zero_re",  64'(re), 64'h0);

      run_conv(32'h4060_0000, 1'b1, v, re, lat);
      chk("disturb_lat", 64'(lat), 64'd3);
      chk("disturb_val", 64'(v),   64'h00E0_0000);

      run_conv(32'h3F80_0000, 1'b0, v, re, lat);
      @(negedge clk);
      bus.start_floating_to_fixed_conversion = 1'b1;
      bus.floating_point_input = 32'h4060_0000;
      @(negedge clk);
      bus.start_floating_to_fixed_conversion = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ready", 64'(bus.fixed_point_number_ready), 64'h0);
      chk("abort_out",   64'(bus.fixed_point_output_reg),   64'h0);
      chk("abort_busy",  64'(bus.busy),                     64'h0);
      reset = 1'b0;
      run_conv(32'h3F00_0000, 1'b0, v, re, lat);
      chk("post_abort_lat", 64'(lat), 64'd3);
      chk("post_abort_val", 64'(v),   64'h0020_0000);

      // Held start: one acceptance every 4 cycles.
      @(negedge clk);
      bus.start_floating_to_fixed_conversion = 1'b1;
      bus.floating_point_input = rand_float();
      pulses = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (bus.fixed_point_number_ready) pulses++;
         bus.floating_point_input = rand_float();
         if (i == 16) bus.start_floating_to_fixed_conversion = 1'b0;
      end
      chk("held_start_pulses", 64'(pulses), 64'd4);
      repeat (4) @(negedge clk);

      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 149) == 0);
         bus.start_floating_to_fixed_conversion = ($urandom_range(0, 2) != 0);
         bus.floating_point_input = rand_float();
      end
      reset = 1'b0;
      bus.start_floating_to_fixed_conversion = 1'b0;
      repeat (6) @(negedge clk);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
